// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS control FSM with retired-instruction counter
module mips_multicycle_ctrl #(
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 16,
    parameter int EN_ADDI = 1,
    parameter int EN_JUMP = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         pc_source,
    output logic               retire,
    output logic               illegal,
    output logic [3:0]         state,
    output logic [CNT_W-1:0]   retired_cnt
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB    = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t     st;
    state_t     dec_next;
    logic       legal;
    logic       is_sw;
    logic [1:0] aop;

    assign state = st;

    always_comb begin
        dec_next = S_FETCH;
        legal    = 1'b1;
        case (opcode)
            OP_R:         dec_next = S_EXEC;
            OP_LW, OP_SW: dec_next = S_MEMADR;
            OP_BEQ:       dec_next = S_BRANCH;
            OP_ADDI: begin
                if (EN_ADDI != 0) dec_next = S_ADDIEX;
                else              legal    = 1'b0;
            end
            OP_J: begin
                if (EN_JUMP != 0) dec_next = S_JUMP;
                else              legal    = 1'b0;
            end
            default:      legal = 1'b0;
        endcase
    end

    // Moore decode of state; only FETCH/MEMWR outputs look at mem_ready
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        aop           = 2'b00;
        pc_source     = 2'b00;
        retire        = 1'b0;
        illegal       = 1'b0;
        case (st)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                illegal   = ~legal;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                retire    = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                aop       = 2'b10;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                aop           = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                retire        = 1'b1;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                retire    = 1'b1;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            default: ;
        endcase
        alu_op = ALUOP_W'(aop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= S_FETCH;
            is_sw       <= 1'b0;
            retired_cnt <= '0;
        end else begin
            if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
            case (st)
                S_FETCH:  if (mem_ready) st <= S_DECODE;
                S_DECODE: begin
                    st    <= dec_next;
                    is_sw <= (opcode == OP_SW);
                end
                S_MEMADR: st <= is_sw ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (mem_ready) st <= S_MEMWB;
                S_MEMWR:  if (mem_ready) st <= S_FETCH;
                S_EXEC:   st <= S_RWB;
                S_ADDIEX: st <= S_ADDIWB;
                // final states of every path and the unused encodings 12-15
                default:  st <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - two-instance bench against an instruction-path reference model
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  op [2];
    logic        mr [2];

    logic        pc_write [2], pc_write_cond [2], i_or_d [2], mem_read [2], mem_write [2];
    logic        ir_write [2], mem_to_reg [2], reg_dst [2], reg_write [2], alu_src_a [2];
    logic [1:0]  alu_src_b [2], alu_op [2], pc_source [2];
    logic        retire [2], illegal [2];
    logic [3:0]  st_o [2];
    logic [15:0] cnt_o0;
    logic [3:0]  cnt_o1;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.ALUOP_W(2), .CNT_W(16), .EN_ADDI(1), .EN_JUMP(1)) u0 (
        .clk(clk), .rst_n(rst_n), .opcode(op[0]), .mem_ready(mr[0]),
        .pc_write(pc_write[0]), .pc_write_cond(pc_write_cond[0]), .i_or_d(i_or_d[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]), .ir_write(ir_write[0]),
        .mem_to_reg(mem_to_reg[0]), .reg_dst(reg_dst[0]), .reg_write(reg_write[0]),
        .alu_src_a(alu_src_a[0]), .alu_src_b(alu_src_b[0]), .alu_op(alu_op[0]),
        .pc_source(pc_source[0]), .retire(retire[0]), .illegal(illegal[0]),
        .state(st_o[0]), .retired_cnt(cnt_o0)
    );

    mips_multicycle_ctrl #(.ALUOP_W(2), .CNT_W(4), .EN_ADDI(0), .EN_JUMP(1)) u1 (
        .clk(clk), .rst_n(rst_n), .opcode(op[1]), .mem_ready(mr[1]),
        .pc_write(pc_write[1]), .pc_write_cond(pc_write_cond[1]), .i_or_d(i_or_d[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]), .ir_write(ir_write[1]),
        .mem_to_reg(mem_to_reg[1]), .reg_dst(reg_dst[1]), .reg_write(reg_write[1]),
        .alu_src_a(alu_src_a[1]), .alu_src_b(alu_src_b[1]), .alu_op(alu_op[1]),
        .pc_source(pc_source[1]), .retire(retire[1]), .illegal(illegal[1]),
        .state(st_o[1]), .retired_cnt(cnt_o1)
    );

    // reference model: current state plus the remaining states of the instruction's path
    int         cs [2];
    int         rest [2][$];
    logic [5:0] cur_op [2];
    logic [5:0] prog [2][$];
    int         cnt_m [2];
    int         cnt_mod [2] = '{65536, 16};
    bit         en_addi [2] = '{1'b1, 1'b0};
    int         stall_f [2], stall_rd [2], stall_wr [2];
    bit         rnd;
    int         vectors = 0;
    int         miscompares = 0;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s[u%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    function automatic void build_path(input int k, input logic [5:0] o);
        rest[k].delete();
        case (o)
            6'b000000: begin rest[k].push_back(6); rest[k].push_back(7); end
            6'b100011: begin rest[k].push_back(2); rest[k].push_back(3); rest[k].push_back(4); end
            6'b101011: begin rest[k].push_back(2); rest[k].push_back(5); end
            6'b000100: rest[k].push_back(8);
            6'b001000: if (en_addi[k]) begin rest[k].push_back(10); rest[k].push_back(11); end
            6'b000010: rest[k].push_back(9);
            default: ;
        endcase
    endfunction

    // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
    //  reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
    function automatic logic [15:0] exp_ctrl(input int s, input logic m);
        logic pcw = 0, pwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rdst = 0, rw = 0, sa = 0;
        logic [1:0] sb = 0, ao = 0, ps = 0;
        case (s)
            0:  begin mrd = 1; sb = 2'b01; pcw = m; irw = m; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin sa = 1; ao = 2'b10; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
            9:  begin pcw = 1; ps = 2'b10; end
            10: begin sa = 1; sb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pcw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, ao, ps};
    endfunction

    function automatic logic [15:0] obs_ctrl(input int k);
        return {pc_write[k], pc_write_cond[k], i_or_d[k], mem_read[k], mem_write[k], ir_write[k],
                mem_to_reg[k], reg_dst[k], reg_write[k], alu_src_a[k], alu_src_b[k], alu_op[k],
                pc_source[k]};
    endfunction

    function automatic logic [31:0] obs_cnt(input int k);
        return (k == 0) ? {16'd0, cnt_o0} : {28'd0, cnt_o1};
    endfunction

    function automatic bit exp_retire(input int k);
        return (cs[k] > 1) && (rest[k].size() == 0) && (cs[k] != 5 || mr[k]);
    endfunction

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 7))
            0: return 6'b000000;
            1: return 6'b100011;
            2: return 6'b101011;
            3: return 6'b000100;
            4: return 6'b001000;
            5: return 6'b000010;
            6: return 6'b111111;
            default: return 6'($urandom);
        endcase
    endfunction

    task automatic check_all(input int k);
        chk("state", k, {28'd0, st_o[k]}, 32'(cs[k]));
        chk("ctrl", k, {16'd0, obs_ctrl(k)}, {16'd0, exp_ctrl(cs[k], mr[k])});
        chk("retire", k, {31'd0, retire[k]}, {31'd0, exp_retire(k)});
        chk("illegal", k, {31'd0, illegal[k]}, {31'd0, (cs[k] == 1 && rest[k].size() == 0)});
        chk("retired_cnt", k, obs_cnt(k), 32'(cnt_m[k]));
    endtask

    task automatic advance(input int k);
        if (exp_retire(k)) cnt_m[k] = (cnt_m[k] + 1) % cnt_mod[k];
        if ((cs[k] == 0 || cs[k] == 3 || cs[k] == 5) && !mr[k]) return;
        if (cs[k] == 0) begin
            cs[k] = 1;
            cur_op[k] = (prog[k].size() != 0) ? prog[k].pop_front() : pick_op();
            build_path(k, cur_op[k]);
        end else begin
            cs[k] = (rest[k].size() != 0) ? rest[k].pop_front() : 0;
        end
    endtask

    // one clock: entered and left at negedge
    task automatic cyc();
        for (int k = 0; k < 2; k++) begin
            if (cs[k] == 0 && stall_f[k] > 0)       begin mr[k] = 1'b0; stall_f[k]--;  end
            else if (cs[k] == 3 && stall_rd[k] > 0) begin mr[k] = 1'b0; stall_rd[k]--; end
            else if (cs[k] == 5 && stall_wr[k] > 0) begin mr[k] = 1'b0; stall_wr[k]--; end
            else mr[k] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            op[k] = (cs[k] == 1) ? cur_op[k] : 6'($urandom);
        end
        #1;
        for (int k = 0; k < 2; k++) check_all(k);
        @(posedge clk);
        for (int k = 0; k < 2; k++) advance(k);
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            cs[k] = 0;
            rest[k].delete();
            cnt_m[k] = 0;
            stall_f[k] = 0; stall_rd[k] = 0; stall_wr[k] = 0;
            check_all(k);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // pushes one instruction for u0 and runs until u0 has left FETCH and come back
    task automatic run_instr0(input logic [5:0] o, input int sf, input int srd, input int swr);
        int n = 0;
        prog[0].push_back(o);
        stall_f[0] = sf; stall_rd[0] = srd; stall_wr[0] = swr;
        while (cs[0] == 0 && n < 40) begin cyc(); n++; end
        while (cs[0] != 0 && n < 40) begin cyc(); n++; end
        chk("instr_timeout", 0, 32'(n < 40), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        rnd   = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mr[k] = 1'b1; op[k] = 6'd0; cs[k] = 0; cnt_m[k] = 0;
            stall_f[k] = 0; stall_rd[k] = 0; stall_wr[k] = 0;
        end
        @(negedge clk);
        reset_pulse();

        for (int i = 0; i < 16; i++) prog[1].push_back(6'b000010);
        prog[1].push_back(6'b001000);
        prog[1].push_back(6'b111111);
        prog[1].push_back(6'b000000);

        run_instr0(6'b000000, 0, 0, 0);
        run_instr0(6'b100011, 0, 2, 0);
        run_instr0(6'b101011, 3, 0, 2);
        run_instr0(6'b111111, 0, 0, 0);
        run_instr0(6'b001000, 0, 0, 0);
        run_instr0(6'b000100, 1, 0, 0);
        run_instr0(6'b000010, 0, 0, 0);
        while (prog[1].size() != 0 && vectors < 20000) cyc();
        for (int i = 0; i < 6; i++) cyc();

        rnd = 1'b1;
        for (int i = 0; i < 400; i++) cyc();

        // abort a load stalled in MEMRD
        rnd = 1'b0;
        prog[0].push_back(6'b100011);
        stall_rd[0] = 6;
        for (int n = 0; n < 60 && cs[0] != 3; n++) cyc();
        chk("reach_memrd", 0, 32'(cs[0]), 32'd3);
        cyc();
        reset_pulse();
        rnd = 1'b1;
        for (int i = 0; i < 60; i++) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multi-cycle MIPS control unit. Successor to the single-cycle combinational opcode decoder.
- A state machine sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives datapath enables and muxes, holds in memory states until the memory handshake completes, and counts retired instructions.
- Sits between the instruction register opcode field and the shared-memory multi-cycle datapath.

Parameters:
- ALUOP_W, 2, width of alu_op. Encodings are zero-extended to this width; must be ≥2.
- CNT_W, 16, width of the retired-instruction counter.
- EN_ADDI, 1, when 1 opcode 6'b001000 (addi) is decoded; when 0 it is illegal.
- EN_JUMP, 1, when 1 opcode 6'b000010 (j) is decoded; when 0 it is illegal.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- i_or_d  out  1  memory address: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  writeback source: 1=MDR, 0=ALUOut
- reg_dst  out  1  destination: 1=rd, 0=rt
- reg_write  out  1  register file write
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2
- alu_op  out  ALUOP_W  00=add, 01=sub, 10=funct
- pc_source  out  2  00=ALU, 01=ALUOut, 10=jump target
- retire  out  1  one-cycle pulse, instruction completed
- illegal  out  1  one-cycle pulse, undecoded opcode
- state  out  4  current state encoding, for debug
- retired_cnt  out  CNT_W  retired instruction count

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Encodings 12–15 are unreachable and return to FETCH.
- Reset (async, rst_n=0): state=FETCH, retired_cnt=0. Outputs follow FETCH decode during and after reset.
- Outputs are Moore decode of state. The only exceptions are the mem_ready-qualified pulses noted below. Any output not listed for a state is 0.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 000000 → EXEC
  - 100011 or 101011 → MEMADR
  - 000100 → BRANCH
  - 001000 → ADDIEX when EN_ADDI=1
  - 000010 → JUMP when EN_JUMP=1
  - otherwise illegal=1 for this cycle, next FETCH, no retire.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next MEMRD if lw, MEMWR if sw. Uses the opcode value held from DECODE.
- MEMRD: mem_read=1, i_or_d=1. Waits on mem_ready, then goes to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, retire=1. Next FETCH.
- MEMWR: mem_write=1, i_or_d=1. Waits on mem_ready; retire=mem_ready; goes to FETCH when mem_ready=1.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0, retire=1. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, retire=1. Next FETCH.
- JUMP: pc_write=1, pc_source=10, retire=1. Next FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, retire=1. Next FETCH.
- Latency from FETCH entry to the retire pulse, with mem_ready=1 every cycle:
  - lw 5 cycles
  - sw, R-type, addi 4 cycles
  - beq, j 3 cycles
- retired_cnt increments by 1 on the clock edge ending any retire=1 cycle. It wraps from 2^CNT_W−1 to 0.
- mem_ready is ignored in states without a memory access.
- rst_n asserted mid-instruction aborts immediately. No retire is issued for the aborted instruction and the count is cleared.

Test Plan:
- Reset released, mem_ready=1, opcode=000000 → states 0,1,6,7,0. retire pulses in state 7 with reg_dst=1; retired_cnt=1.
- lw (100011) with mem_ready low 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0. Stays in state 3 while mem_ready=0 with mem_read=1, i_or_d=1. retire only in state 4.
- sw with mem_ready=0 for 3 cycles in FETCH → ir_write=pc_write=0 until mem_ready=1, then path 1,2,5. mem_write=1 and retire on mem_ready.
- opcode 111111, then addi with EN_ADDI=0 → illegal=1 in DECODE, back to FETCH, retired_cnt unchanged. With EN_ADDI=1, addi path 10,11 retires.
- CNT_W=4, 16 back-to-back j (000010) → pc_source=10 and pc_write=1 in state 9. retired_cnt wraps 15→0.
- rst_n pulsed low while in state 3 → state=0 asynchronously, retired_cnt=0, no retire pulse.
